// File: rtl/door_direction_detector_if.sv
// Sensor inputs and passage-event outputs of the door direction detector.
// The master side drives the sensors; the slave side is the detector.
interface door_direction_detector_if;
  logic sensor_outer;
  logic sensor_inner;
  logic enter_pulse;
  logic exit_pulse;
  logic busy;
  logic fault;

  modport master (
    output sensor_outer, sensor_inner,
    input  enter_pulse, exit_pulse, busy, fault
  );

  modport slave (
    input  sensor_outer, sensor_inner,
    output enter_pulse, exit_pulse, busy, fault
  );
endinterface

// File: rtl/door_direction_detector.sv
// Two-beam door passage detector: sync + debounce each beam, then an entry/exit FSM.
// Raw edge reaches the FSM DEBOUNCE_CYCLES+2 cycles later; registered outputs follow one cycle after.
module door_direction_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input logic                      clk,
  input logic                      rst_n,
  door_direction_detector_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    E1    = 3'd1,
    E2    = 3'd2,
    E3    = 3'd3,
    X1    = 3'd4,
    X2    = 3'd5,
    X3    = 3'd6,
    ABORT = 3'd7
  } state_t;

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Bit 1 carries the outer beam, bit 0 the inner beam.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [7:0] db_cnt [2];

  assign raw = {bus.sensor_outer, bus.sensor_inner};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      deb       <= 2'b00;
      db_cnt[0] <= 8'd0;
      db_cnt[1] <= 8'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] != deb[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            deb[k]    <= sync2[k];
            db_cnt[k] <= 8'd0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 8'd1;
          end
        end else begin
          db_cnt[k] <= 8'd0;
        end
      end
    end
  end

  state_t      state;
  state_t      state_nxt;
  logic [15:0] to_cnt;
  logic        mid_passage;
  logic        timed_out;
  logic        enter_nxt;
  logic        exit_nxt;
  logic        fault_nxt;

  assign mid_passage = (state != IDLE) && (state != ABORT);
  assign timed_out   = mid_passage && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    fault_nxt = 1'b0;
    if (timed_out) begin
      state_nxt = ABORT;
      fault_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: case (deb)
          2'b10: state_nxt = E1;
          2'b01: state_nxt = X1;
          2'b11: begin state_nxt = ABORT; fault_nxt = 1'b1; end
          default: state_nxt = IDLE;
        endcase
        E1: case (deb)
          2'b11: state_nxt = E2;
          2'b00: state_nxt = IDLE;
          2'b01: begin state_nxt = ABORT; fault_nxt = 1'b1; end
          default: state_nxt = E1;
        endcase
        E2: case (deb)
          2'b01: state_nxt = E3;
          2'b10: state_nxt = E1;
          2'b00: begin state_nxt = ABORT; fault_nxt = 1'b1; end
          default: state_nxt = E2;
        endcase
        E3: case (deb)
          2'b00: begin state_nxt = IDLE; enter_nxt = 1'b1; end
          2'b11: state_nxt = E2;
          2'b10: begin state_nxt = ABORT; fault_nxt = 1'b1; end
          default: state_nxt = E3;
        endcase
        X1: case (deb)
          2'b11: state_nxt = X2;
          2'b00: state_nxt = IDLE;
          2'b10: begin state_nxt = ABORT; fault_nxt = 1'b1; end
          default: state_nxt = X1;
        endcase
        X2: case (deb)
          2'b10: state_nxt = X3;
          2'b01: state_nxt = X1;
          2'b00: begin state_nxt = ABORT; fault_nxt = 1'b1; end
          default: state_nxt = X2;
        endcase
        X3: case (deb)
          2'b00: begin state_nxt = IDLE; exit_nxt = 1'b1; end
          2'b11: state_nxt = X2;
          2'b01: begin state_nxt = ABORT; fault_nxt = 1'b1; end
          default: state_nxt = X3;
        endcase
        default: state_nxt = (deb == 2'b00) ? IDLE : ABORT;
      endcase
    end
  end

  // The timeout counter restarts on every state change, so it measures dwell in one state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      to_cnt          <= 16'd0;
      bus.enter_pulse <= 1'b0;
      bus.exit_pulse  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.fault       <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.enter_pulse <= enter_nxt;
      bus.exit_pulse  <= exit_nxt;
      bus.busy        <= (state_nxt != IDLE);
      bus.fault       <= fault_nxt;
      if ((state_nxt != state) || !mid_passage)
        to_cnt <= 16'd0;
      else
        to_cnt <= to_cnt + 16'd1;
    end
  end

endmodule
